rf_wport_arbiter: RTL and testbench
===================================

# rf_wport_arbiter

Write-port arbiter and scoreboard for the 32×32 register file, which has one write port. It gives the single port to the in-order WB stage or to the long-latency multiply/divide unit (MDU). WB always wins, and MDU results that lose arbitration are held in a small queue. A per-register busy mask tracks MDU destinations and produces the decode-stage stall.

## Interface
Parameters:
- DEPTH, 2: MDU result queue entries (≥1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- wb_we  in  1  WB stage write request (cannot be stalled).
- wb_rw  in  5  WB destination register.
- wb_rd  in  32  WB write data.
- wb_pc  in  32  PC of the WB instruction.
- mdu_valid  in  1  MDU result valid.
- mdu_ready  out  1  MDU result accepted this cycle when high with mdu_valid.
- mdu_rw  in  5  MDU destination register.
- mdu_rd  in  32  MDU result data.
- mdu_pc  in  32  PC of the MDU instruction.
- iss_valid  in  1  MDU op issued this cycle.
- iss_rw  in  5  destination of the issued MDU op.
- dec_ra  in  5  decode source A.
- dec_rb  in  5  decode source B.
- dec_rw  in  5  decode destination.
- stall  out  1  decode must hold this cycle.
- rf_we  out  1  register-file write enable.
- rf_rw  out  5  register-file write address.
- rf_rd  out  32  register-file write data.
- rf_pc  out  32  PC forwarded to the register-file trace.

## Operation
- WB request: wb_we=1 and wb_rw≠0. A WB write to r0 is dropped (rf_we=0).
- Port grant priority: WB request, then queue head, then a direct MDU result (only when the queue is empty).
- mdu_ready = (count < DEPTH). It is combinational from registered count only, never from mdu_valid.
- An accepted MDU result is handled as follows:
  - Written directly in the same cycle if the port is free and the queue is empty.
  - Otherwise pushed to the queue tail.
  - Dropped if mdu_rw=0: no write, no busy change.
- The queue head is popped and written in any cycle without a WB request.
- If the queue pops and accepts a new result in the same cycle, it pushes to the tail and count is unchanged.
- MDU results are written strictly in acceptance order.
- busy[31:0] scoreboard:
  - iss_valid with iss_rw≠0 sets busy[iss_rw].
  - Any MDU-sourced rf write clears busy[rf_rw].
  - If set and clear hit the same index in one cycle, set wins.
  - busy[0] is never set.
- stall = (dec_ra≠0 & busy[dec_ra]) | (dec_rb≠0 & busy[dec_rb]) | (dec_rw≠0 & busy[dec_rw]).
  - This covers RAW and WAW hazards against pending MDU ops.
  - stall is combinational from registered busy.
- WB writing a register that is busy is an illegal upstream condition. It is not checked; both writes occur in grant order.

## Timing
- All rf_* outputs are combinational.
- Direct MDU write: 0 cycles from acceptance.
- Queued entry accepted in cycle N: written in cycle N+1 at the earliest.
- busy set by an issue in cycle N: stall visible from N+1. busy clears on the edge closing the write cycle.
- Reset values (asynchronous, while reset=0):
  - count=0, queue empty, busy=0.
  - mdu_ready=1, stall=0, rf_we=0 (the WB/MDU inputs are ignored).
  - rf_rw=0, rf_rd=0, rf_pc=0.
- Reset mid-operation discards queued results and all busy bits. Upstream reissues.
- Wrap-around: queue pointers wrap modulo DEPTH. count ranges 0..DEPTH.

## Structure
- Shared package rf_pkg:
  - REG_AW=5, DATA_W=32, NREG=32.
  - Struct wr_req_t {rw[4:0], rd[31:0], pc[31:0]}.
  - Source enum {SRC_NONE, SRC_WB, SRC_QUEUE, SRC_MDU}.
- One sub-module: rf_wq_fifo. It is a generic synchronous FIFO of wr_req_t with DEPTH, push/pop/full/empty/count and an asynchronous active-low reset.
- Grant mux and scoreboard live in the top module.

## Test plan
- Reset mid-traffic:
  - Stimulus: fill the queue with 2 entries and busy={r5,r6}, then pulse reset=0.
  - Required: count=0, busy=0, mdu_ready=1, stall=0, rf_we=0, and no queued write ever appears.
- Idle-port direct write:
  - Stimulus: wb_we=0; mdu_valid, mdu_rw=7, mdu_rd=0xDEADBEEF.
  - Required: same cycle rf_we=1, rf_rw=7, rf_rd=0xDEADBEEF; busy[7] clears next edge.
- Conflict then drain:
  - Stimulus: WB (r3, 0x11) and MDU (r9, 0x22) in the same cycle, then WB idle.
  - Required: cycle 0 writes r3=0x11; cycle 1 writes r9=0x22; count returns to 0.
- Full queue back-pressure:
  - Stimulus: WB busy 4 cycles while the MDU offers r10, r11, r12.
  - Required: mdu_ready=0 after 2 accepts; r10 and r11 are written in order once WB idles; r12 is accepted as soon as an entry frees.
- Scoreboard stall:
  - Stimulus: iss r4 in cycle 0; decode dec_ra=4 from cycle 1.
  - Required: stall=1 until the MDU write of r4, then 0 on the following cycle. dec_ra=0 never stalls.
- r0 handling:
  - Stimulus: WB r0 write; MDU result with rw=0; issue with iss_rw=0.
  - Required: rf_we=0 for both writes, MDU result accepted, busy unchanged.

Source files
------------

// File: rtl/rf_wport_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter.
//   REG_AW/DATA_W/NREG : register-file geometry
//   wr_req_t           : one pending register write (dest, data, trace PC)
//   src_e              : which requester owns the write port this cycle
package rf_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;
    localparam int NREG   = 32;

    typedef struct packed {
        logic [REG_AW-1:0] rw;
        logic [DATA_W-1:0] rd;
        logic [DATA_W-1:0] pc;
    } wr_req_t;

    typedef enum logic [1:0] {
        SRC_NONE  = 2'd0,
        SRC_WB    = 2'd1,
        SRC_QUEUE = 2'd2,
        SRC_MDU   = 2'd3
    } src_e;

    // r0 is hard-wired to zero, so only non-zero destinations are real writes.
    function automatic logic reg_live(input logic [REG_AW-1:0] r);
        return (r != {REG_AW{1'b0}});
    endfunction

endpackage

// File: rtl/rf_wport_arbiter_if.sv
// Bus bundle between the pipeline (master) and the write-port arbiter (slave).
//   wb_*  : WB-stage write request        mdu_* : MDU result handshake
//   iss_* : MDU issue (scoreboard set)    dec_* : decode operands for stall
//   rf_*  : register-file write port      stall : decode hold
interface rf_wport_if;
    logic        wb_we;
    logic [4:0]  wb_rw;
    logic [31:0] wb_rd;
    logic [31:0] wb_pc;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_rw;
    logic [31:0] mdu_rd;
    logic [31:0] mdu_pc;
    logic        iss_valid;
    logic [4:0]  iss_rw;
    logic [4:0]  dec_ra;
    logic [4:0]  dec_rb;
    logic [4:0]  dec_rw;
    logic        stall;
    logic        rf_we;
    logic [4:0]  rf_rw;
    logic [31:0] rf_rd;
    logic [31:0] rf_pc;

    modport master (
        output wb_we, wb_rw, wb_rd, wb_pc,
        output mdu_valid, mdu_rw, mdu_rd, mdu_pc,
        input  mdu_ready,
        output iss_valid, iss_rw, dec_ra, dec_rb, dec_rw,
        input  stall, rf_we, rf_rw, rf_rd, rf_pc
    );

    modport slave (
        input  wb_we, wb_rw, wb_rd, wb_pc,
        input  mdu_valid, mdu_rw, mdu_rd, mdu_pc,
        output mdu_ready,
        input  iss_valid, iss_rw, dec_ra, dec_rb, dec_rw,
        output stall, rf_we, rf_rw, rf_rd, rf_pc
    );
endinterface

// File: rtl/rf_wq_fifo.sv
// Synchronous FIFO of wr_req_t entries holding MDU results that lost the port.
//   clk, reset (async active-low) ; push/din ; pop/dout (head, show-ahead)
//   full, empty, count (0..DEPTH)
// Push while full and pop while empty are ignored.
module rf_wq_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  wr_req_t       din,
    input  logic          pop,
    output wr_req_t       dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

    wr_req_t       mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_s;
    logic          pop_s;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? {PW{1'b0}} : (p + PW'(1'b1));
    endfunction

    assign full   = (count_r == DEPTH_C);
    assign empty  = (count_r == {CW{1'b0}});
    assign count  = count_r;
    assign dout   = mem_r[rd_ptr_r];
    assign push_s = push & ~full;
    assign pop_s  = pop & ~empty;

    // Storage, pointers and occupancy; a simultaneous push and pop keeps count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{rw: 5'd0, rd: 32'd0, pc: 32'd0};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Write-port arbiter and MDU scoreboard for the 32x32 register file.
//   clk, reset (async active-low)
//   bus (rf_wport_if.slave): WB and MDU write requests in, the single
//   register-file write port out, plus the busy-register decode stall.
// Grant order: WB, then queued MDU result, then a direct MDU result when the
// queue is empty, so MDU results always reach the file in acceptance order.
module rf_wport_arbiter
    import rf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    rf_wport_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    wr_req_t         mdu_req_s;
    wr_req_t         q_head_s;
    logic            q_full_s;
    logic            q_empty_s;
    logic [CW-1:0]   q_count_s;
    logic            wb_req_s;
    logic            accept_s;
    logic            acc_live_s;
    logic            direct_s;
    logic            push_s;
    logic            pop_s;
    src_e            src_s;
    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busy_set_s;
    logic [NREG-1:0] busy_clr_s;
    logic [NREG-1:0] busy_nxt_s;

    assign mdu_req_s = '{rw: bus.mdu_rw, rd: bus.mdu_rd, pc: bus.mdu_pc};

    // Ready depends only on registered occupancy so the MDU never sees a loop.
    assign bus.mdu_ready = (q_count_s < DEPTH_C);

    assign wb_req_s   = bus.wb_we & reg_live(bus.wb_rw);
    assign accept_s   = bus.mdu_valid & bus.mdu_ready;
    // Results for r0 are accepted and silently discarded.
    assign acc_live_s = accept_s & reg_live(bus.mdu_rw);
    assign direct_s   = acc_live_s & ~wb_req_s & q_empty_s;
    assign push_s     = acc_live_s & ~direct_s & ~q_full_s;
    assign pop_s      = ~wb_req_s & ~q_empty_s;

    rf_wq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .din   (mdu_req_s),
        .pop   (pop_s),
        .dout  (q_head_s),
        .full  (q_full_s),
        .empty (q_empty_s),
        .count (q_count_s)
    );

    // Port owner; nothing is granted while reset is held.
    always_comb begin
        src_s = SRC_NONE;
        if (!reset) begin
            src_s = SRC_NONE;
        end else if (wb_req_s) begin
            src_s = SRC_WB;
        end else if (!q_empty_s) begin
            src_s = SRC_QUEUE;
        end else if (direct_s) begin
            src_s = SRC_MDU;
        end else begin
            src_s = SRC_NONE;
        end
    end

    // Register-file write port mux.
    always_comb begin
        bus.rf_we = 1'b0;
        bus.rf_rw = 5'd0;
        bus.rf_rd = 32'd0;
        bus.rf_pc = 32'd0;
        case (src_s)
            SRC_WB: begin
                bus.rf_we = 1'b1;
                bus.rf_rw = bus.wb_rw;
                bus.rf_rd = bus.wb_rd;
                bus.rf_pc = bus.wb_pc;
            end
            SRC_QUEUE: begin
                bus.rf_we = 1'b1;
                bus.rf_rw = q_head_s.rw;
                bus.rf_rd = q_head_s.rd;
                bus.rf_pc = q_head_s.pc;
            end
            SRC_MDU: begin
                bus.rf_we = 1'b1;
                bus.rf_rw = mdu_req_s.rw;
                bus.rf_rd = mdu_req_s.rd;
                bus.rf_pc = mdu_req_s.pc;
            end
            default: begin
                bus.rf_we = 1'b0;
            end
        endcase
    end

    // Scoreboard next state: issue sets, MDU-sourced write clears, set wins.
    always_comb begin
        busy_set_s = {NREG{1'b0}};
        busy_clr_s = {NREG{1'b0}};
        if (bus.iss_valid && reg_live(bus.iss_rw)) begin
            busy_set_s[bus.iss_rw] = 1'b1;
        end else begin
            busy_set_s = {NREG{1'b0}};
        end
        if ((src_s == SRC_QUEUE) || (src_s == SRC_MDU)) begin
            busy_clr_s[bus.rf_rw] = 1'b1;
        end else begin
            busy_clr_s = {NREG{1'b0}};
        end
        busy_nxt_s    = (busy_r & ~busy_clr_s) | busy_set_s;
        busy_nxt_s[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // RAW/WAW hazard against any outstanding MDU destination.
    assign bus.stall = (reg_live(bus.dec_ra) & busy_r[bus.dec_ra])
                     | (reg_live(bus.dec_rb) & busy_r[bus.dec_rb])
                     | (reg_live(bus.dec_rw) & busy_r[bus.dec_rw]);

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed self-checking bench for rf_wport_arbiter (DEPTH=2).
module tb_rf_wport_arbiter;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    rf_wport_if bus ();

    rf_wport_arbiter #(.DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.wb_we     = 1'b0; bus.wb_rw  = 5'd0; bus.wb_rd  = 32'd0; bus.wb_pc  = 32'd0;
        bus.mdu_valid = 1'b0; bus.mdu_rw = 5'd0; bus.mdu_rd = 32'd0; bus.mdu_pc = 32'd0;
        bus.iss_valid = 1'b0; bus.iss_rw = 5'd0;
        bus.dec_ra    = 5'd0; bus.dec_rb = 5'd0; bus.dec_rw = 5'd0;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] rw, input logic [31:0] rd);
        bus.wb_we = 1'b1; bus.wb_rw = rw; bus.wb_rd = rd; bus.wb_pc = 32'h0000_1000 + 32'(rw);
    endtask

    task automatic mdu(input logic [4:0] rw, input logic [31:0] rd);
        bus.mdu_valid = 1'b1; bus.mdu_rw = rw; bus.mdu_rd = rd; bus.mdu_pc = 32'h0000_2000 + 32'(rw);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        idle_inputs();
        // Inputs active during reset must be ignored.
        wb(5'd3, 32'h55);
        mdu(5'd4, 32'h66);
        #2;
        check_val("rst_ready", 64'(bus.mdu_ready), 64'd1);
        check_val("rst_we",    64'(bus.rf_we),     64'd0);
        check_val("rst_rw",    64'(bus.rf_rw),     64'd0);
        check_val("rst_rd",    64'(bus.rf_rd),     64'd0);
        check_val("rst_pc",    64'(bus.rf_pc),     64'd0);
        check_val("rst_stall", 64'(bus.stall),     64'd0);
        tick();
        idle_inputs();
        reset = 1'b1;
        tick();

        // Idle-port direct write, busy[7] set first.
        bus.iss_valid = 1'b1; bus.iss_rw = 5'd7;
        tick();
        idle_inputs();
        bus.dec_ra = 5'd7;
        mdu(5'd7, 32'hDEAD_BEEF);
        #2;
        check_val("dir_stall", 64'(bus.stall), 64'd1);
        check_val("dir_we",    64'(bus.rf_we), 64'd1);
        check_val("dir_rw",    64'(bus.rf_rw), 64'd7);
        check_val("dir_rd",    64'(bus.rf_rd), 64'hDEAD_BEEF);
        check_val("dir_pc",    64'(bus.rf_pc), 64'h2007);
        tick();
        bus.mdu_valid = 1'b0;
        #2;
        check_val("dir_busy_clr", 64'(bus.stall), 64'd0);
        check_val("dir_count",    64'(dut.q_count_s), 64'd0);
        tick();

        // Conflict then drain.
        idle_inputs();
        bus.iss_valid = 1'b1; bus.iss_rw = 5'd9;
        tick();
        idle_inputs();
        wb(5'd3, 32'h11);
        mdu(5'd9, 32'h22);
        #2;
        check_val("cf0_we", 64'(bus.rf_we), 64'd1);
        check_val("cf0_rw", 64'(bus.rf_rw), 64'd3);
        check_val("cf0_rd", 64'(bus.rf_rd), 64'h11);
        check_val("cf0_pc", 64'(bus.rf_pc), 64'h1003);
        tick();
        idle_inputs();
        #2;
        check_val("cf1_count", 64'(dut.q_count_s), 64'd1);
        check_val("cf1_we",    64'(bus.rf_we), 64'd1);
        check_val("cf1_rw",    64'(bus.rf_rw), 64'd9);
        check_val("cf1_rd",    64'(bus.rf_rd), 64'h22);
        check_val("cf1_pc",    64'(bus.rf_pc), 64'h2009);
        tick();
        check_val("cf_count0", 64'(dut.q_count_s), 64'd0);
        check_val("cf_busy0",  64'(dut.busy_r), 64'd0);

        // Full-queue back-pressure.
        for (int i = 0; i < 3; i++) begin
            bus.iss_valid = 1'b1; bus.iss_rw = 5'(10 + i);
            tick();
        end
        idle_inputs();
        check_val("bp_busy", 64'(dut.busy_r), 64'h0000_1C00);
        for (int i = 0; i < 4; i++) begin
            wb(5'(20 + i), 32'h1000 + 32'(i));
            mdu((i == 0) ? 5'd10 : ((i == 1) ? 5'd11 : 5'd12), (i == 0) ? 32'hAA : ((i == 1) ? 32'hAB : 32'hAC));
            #2;
            check_val("bp_wb_rw", 64'(bus.rf_rw), 64'(20 + i));
            check_val("bp_ready", 64'(bus.mdu_ready), (i < 2) ? 64'd1 : 64'd0);
            tick();
        end
        bus.wb_we = 1'b0;
        #2;
        check_val("bp_d0_rw",    64'(bus.rf_rw), 64'd10);
        check_val("bp_d0_rd",    64'(bus.rf_rd), 64'hAA);
        check_val("bp_d0_ready", 64'(bus.mdu_ready), 64'd0);
        tick();
        #2;
        check_val("bp_d1_rw",    64'(bus.rf_rw), 64'd11);
        check_val("bp_d1_rd",    64'(bus.rf_rd), 64'hAB);
        check_val("bp_d1_ready", 64'(bus.mdu_ready), 64'd1);
        tick();
        idle_inputs();
        #2;
        check_val("bp_d2_we", 64'(bus.rf_we), 64'd1);
        check_val("bp_d2_rw", 64'(bus.rf_rw), 64'd12);
        check_val("bp_d2_rd", 64'(bus.rf_rd), 64'hAC);
        tick();
        check_val("bp_count0", 64'(dut.q_count_s), 64'd0);
        check_val("bp_busy0",  64'(dut.busy_r), 64'd0);
        #2;
        check_val("bp_idle_we", 64'(bus.rf_we), 64'd0);
        tick();

        // Scoreboard stall.
        bus.iss_valid = 1'b1; bus.iss_rw = 5'd4; bus.dec_ra = 5'd4;
        #2;
        check_val("sb_c0", 64'(bus.stall), 64'd0);
        tick();
        bus.iss_valid = 1'b0;
        #2;
        check_val("sb_ra", 64'(bus.stall), 64'd1);
        bus.dec_ra = 5'd0; bus.dec_rb = 5'd4;
        #1;
        check_val("sb_rb", 64'(bus.stall), 64'd1);
        bus.dec_rb = 5'd0; bus.dec_rw = 5'd4;
        #1;
        check_val("sb_rw", 64'(bus.stall), 64'd1);
        bus.dec_rw = 5'd0;
        #1;
        check_val("sb_zero", 64'(bus.stall), 64'd0);
        tick();
        bus.dec_ra = 5'd4;
        #2;
        check_val("sb_hold", 64'(bus.stall), 64'd1);
        tick();
        mdu(5'd4, 32'h44);
        #2;
        check_val("sb_wr_rw",    64'(bus.rf_rw), 64'd4);
        check_val("sb_wr_stall", 64'(bus.stall), 64'd1);
        tick();
        bus.mdu_valid = 1'b0;
        #2;
        check_val("sb_release", 64'(bus.stall), 64'd0);
        tick();

        // r0 handling.
        idle_inputs();
        wb(5'd0, 32'h77);
        #2;
        check_val("r0_wb_we", 64'(bus.rf_we), 64'd0);
        tick();
        idle_inputs();
        mdu(5'd0, 32'h88);
        bus.iss_valid = 1'b1; bus.iss_rw = 5'd0;
        #2;
        check_val("r0_mdu_ready", 64'(bus.mdu_ready), 64'd1);
        check_val("r0_mdu_we",    64'(bus.rf_we), 64'd0);
        tick();
        idle_inputs();
        check_val("r0_count", 64'(dut.q_count_s), 64'd0);
        check_val("r0_busy",  64'(dut.busy_r), 64'd0);
        #2;
        check_val("r0_no_wr", 64'(bus.rf_we), 64'd0);
        tick();

        // Reset mid-traffic.
        bus.iss_valid = 1'b1; bus.iss_rw = 5'd5;
        tick();
        bus.iss_rw = 5'd6;
        tick();
        idle_inputs();
        wb(5'd1, 32'h1); mdu(5'd5, 32'h55);
        tick();
        wb(5'd2, 32'h2); mdu(5'd6, 32'h66);
        tick();
        idle_inputs();
        bus.dec_ra = 5'd5;
        check_val("mr_count2", 64'(dut.q_count_s), 64'd2);
        check_val("mr_busy",   64'(dut.busy_r), 64'h60);
        reset = 1'b0;
        #1;
        check_val("mr_count",  64'(dut.q_count_s), 64'd0);
        check_val("mr_busy0",  64'(dut.busy_r), 64'd0);
        check_val("mr_ready",  64'(bus.mdu_ready), 64'd1);
        check_val("mr_stall",  64'(bus.stall), 64'd0);
        check_val("mr_we",     64'(bus.rf_we), 64'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            check_val("mr_no_wr", 64'(bus.rf_we), 64'd0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
